// File: rtl/config_sequencer_pkg.sv
// Shared types for the config sequencer: FSM states, default field widths,
// and the serial chain length helper.
package config_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DefClockConfigWidth = 6;
  localparam int DefScaleWidth       = 6;

  function automatic int chain_len(input int clockConfigWidth, input int scaleWidth);
    return clockConfigWidth + 2 * scaleWidth;
  endfunction

endpackage

// File: rtl/config_sequencer_if.sv
// Start handshake, parallel config, serial chain pins and readback of the config sequencer.
// master = requester/chain side, slave = the sequencer.
interface config_sequencer_if
  import config_sequencer_pkg::*;
#(
  parameter int ClockConfigWidth = DefClockConfigWidth,
  parameter int ScaleWidth       = DefScaleWidth
) ();

  logic                        startValid;
  logic                        startReady;
  logic [ClockConfigWidth-1:0] clockConfigIn;
  logic [ScaleWidth-1:0]       adcScaleIn;
  logic [ScaleWidth-1:0]       dacScaleIn;
  logic                        serialEn;
  logic                        serialIn;
  logic                        serialOut;
  logic                        busy;
  logic                        done;
  logic [ClockConfigWidth-1:0] rbClockConfig;
  logic [ScaleWidth-1:0]       rbAdcScale;
  logic [ScaleWidth-1:0]       rbDacScale;

  modport master (
    output startValid, clockConfigIn, adcScaleIn, dacScaleIn, serialOut,
    input  startReady, serialEn, serialIn, busy, done,
    input  rbClockConfig, rbAdcScale, rbDacScale
  );

  modport slave (
    input  startValid, clockConfigIn, adcScaleIn, dacScaleIn, serialOut,
    output startReady, serialEn, serialIn, busy, done,
    output rbClockConfig, rbAdcScale, rbDacScale
  );

endinterface

// File: rtl/config_sequencer_shifter.sv
// tx/rx shift registers and bit counter; lastShift flags the final shift edge.
// rx exists only with CONFIG_SEQ_READBACK_EN; otherwise rxNext is 0 and serialOut is ignored.
module config_sequencer_shifter
  import config_sequencer_pkg::*;
#(
  parameter int ClockConfigWidth = DefClockConfigWidth,
  parameter int ScaleWidth       = DefScaleWidth,
  localparam int ChainLen        = chain_len(ClockConfigWidth, ScaleWidth),
  localparam int CntWidth        = $clog2(ChainLen + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift,
  input  logic [ChainLen-1:0] loadData,
  input  logic                serialOut,
  output logic                txMsb,
  output logic                lastShift,
  output logic [ChainLen-1:0] rxNext
);

  logic [ChainLen-1:0] tx;
  logic [CntWidth-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx    <= '0;
      count <= '0;
    end else if (load) begin
      tx    <= loadData;
      count <= '0;
    end else if (shift) begin
      tx <= {tx[ChainLen-2:0], 1'b0};
      // Saturate so the counter never wraps if shift were held too long.
      if (count != CntWidth'(ChainLen)) begin
        count <= count + CntWidth'(1);
      end
    end
  end

  assign txMsb     = tx[ChainLen-1];
  assign lastShift = shift && (count == CntWidth'(ChainLen - 1));

`ifdef CONFIG_SEQ_READBACK_EN
  logic [ChainLen-1:0] rx;

  // Chain MSB leaves first, so rx fills MSB-first and ends equal to the old chain.
  assign rxNext = {rx[ChainLen-2:0], serialOut};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx <= '0;
    end else if (shift) begin
      rx <= rxNext;
    end
  end
`else
  logic unusedSerialOut;
  assign unusedSerialOut = serialOut;
  assign rxNext          = '0;
`endif

endmodule

// File: rtl/config_sequencer.sv
// Shifts {dac, adc, clock} MSB-first into the config chain: ChainLen shift cycles, then a one-cycle done.
// startReady only in IDLE, requests elsewhere are dropped; CONFIG_SEQ_READBACK_EN enables rb* readback.
module config_sequencer
  import config_sequencer_pkg::*;
#(
  parameter int ClockConfigWidth = DefClockConfigWidth,
  parameter int ScaleWidth       = DefScaleWidth
) (
  input logic               clk,
  input logic               reset,
  config_sequencer_if.slave bus
);

  localparam int ChainLen = chain_len(ClockConfigWidth, ScaleWidth);

  state_t              state;
  logic                startReady;
  logic                serialEn;
  logic                busy;
  logic                done;
  logic                accept;
  logic                shift;
  logic                txMsb;
  logic                lastShift;
  logic [ChainLen-1:0] loadData;
  logic [ChainLen-1:0] rxNext;

  assign accept   = bus.startValid && startReady;
  assign shift    = (state == SHIFT);
  assign loadData = {bus.dacScaleIn, bus.adcScaleIn, bus.clockConfigIn};

  config_sequencer_shifter #(
    .ClockConfigWidth(ClockConfigWidth),
    .ScaleWidth      (ScaleWidth)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift    (shift),
    .loadData (loadData),
    .serialOut(bus.serialOut),
    .txMsb    (txMsb),
    .lastShift(lastShift),
    .rxNext   (rxNext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      startReady <= 1'b1;
      serialEn   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SHIFT;
            startReady <= 1'b0;
            serialEn   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          if (lastShift) begin
            state    <= DONE;
            serialEn <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          startReady <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          startReady <= 1'b1;
          serialEn   <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.startReady = startReady;
  assign bus.serialEn   = serialEn;
  assign bus.serialIn   = serialEn & txMsb;
  assign bus.busy       = busy;
  assign bus.done       = done;

`ifdef CONFIG_SEQ_READBACK_EN
  logic [ChainLen-1:0] rb;

  // Capture on the final shift edge so rb is already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rb <= '0;
    end else if (lastShift) begin
      rb <= rxNext;
    end
  end

  assign bus.rbClockConfig = rb[ClockConfigWidth-1:0];
  assign bus.rbAdcScale    = rb[ClockConfigWidth+ScaleWidth-1:ClockConfigWidth];
  assign bus.rbDacScale    = rb[ChainLen-1:ClockConfigWidth+ScaleWidth];
`else
  logic unusedReadback;
  assign unusedReadback    = ^rxNext;
  assign bus.rbClockConfig = '0;
  assign bus.rbAdcScale    = '0;
  assign bus.rbDacScale    = '0;
`endif

endmodule

// File: doc/config_sequencer.md
CONFIG_SEQUENCER -- requirements
Module: config_sequencer

Interface
REQ-001 Parameter ClockConfigWidth, default 6, clock-configuration field width.
REQ-002 Parameter ScaleWidth, default 6, width of each ADC/DAC scale field.
REQ-003 Localparam ChainLen = ClockConfigWidth + 2*ScaleWidth (18 at defaults); this is the serial chain length.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 startValid  input  1  request to load a new configuration.
REQ-007 startReady  output  1  high only in IDLE; a request is accepted when startValid && startReady.
REQ-008 clockConfigIn / adcScaleIn / dacScaleIn  input  ClockConfigWidth / ScaleWidth / ScaleWidth  parallel config to load, sampled on acceptance.
REQ-009 serialEn / serialIn  output  1 / 1  drive the config shift chain.
REQ-010 serialOut  input  1  chain MSB, fed back from the chain.
REQ-011 busy  output  1  high in SHIFT and DONE.
REQ-012 done  output  1  one-cycle pulse when a load completes.
REQ-013 rbClockConfig / rbAdcScale / rbDacScale  output  field widths  previous chain contents, captured during the last load.

Function
REQ-014 States: IDLE, SHIFT, DONE. IDLE->SHIFT on acceptance; SHIFT->DONE after ChainLen shift cycles; DONE->IDLE unconditionally after one cycle.
REQ-015 On acceptance, a tx register SHALL load {dacScaleIn, adcScaleIn, clockConfigIn}, and a bit counter SHALL clear to 0.
REQ-016 In SHIFT: serialEn=1; serialIn=tx MSB; each cycle tx shifts left by one and the counter increments.
REQ-017 After exactly ChainLen SHIFT cycles, the chain holds the accepted config in field order {dac, adc, clock}; the first-shifted bit ends at the chain MSB.
REQ-018 serialEn SHALL be 0 in IDLE and DONE; serialIn SHALL be 0 whenever serialEn=0.
REQ-019 Latency: acceptance at edge N; serialEn high for cycles N+1..N+ChainLen; done high in cycle N+ChainLen+1; startReady high again in cycle N+ChainLen+2.
REQ-020 startValid outside IDLE SHALL be ignored, with no queuing; input field changes after acceptance SHALL have no effect.
REQ-021 Counter width SHALL be $clog2(ChainLen+1); the terminal condition is counter == ChainLen-1 on the final shift edge, with no wrap past it.
REQ-022 A simultaneous DONE->IDLE transition and a held startValid SHALL be accepted one cycle later, when startReady is high.

Reset
REQ-023 reset SHALL force IDLE, tx=0, counter=0, serialEn=0, serialIn=0, busy=0, done=0, and all rb* outputs to 0; startReady=1 in the cycle after reset deasserts.
REQ-024 reset during SHIFT SHALL abort the load immediately with no done pulse; a partial chain is not repaired.

Configuration
REQ-025 Macro CONFIG_SEQ_READBACK_EN: when defined, an rx register SHALL shift in serialOut on every SHIFT edge, MSB first; in DONE, rb* SHALL update from rx with the previous chain contents and hold until the next DONE.
REQ-026 Without CONFIG_SEQ_READBACK_EN: no rx register; rb* SHALL be constant 0; serialOut is unused.

Structure
REQ-027 The shared package SHALL hold the state enum (IDLE, SHIFT, DONE), default widths, and the ChainLen function.
REQ-028 One sub-module, config_sequencer_shifter (tx/rx shift registers plus counter), SHALL be instantiated by an FSM top.

Verification
REQ-029 Benches SHALL pair the block with the real config shift chain, both reset together.
REQ-030 After reset, load clock=0x2A, adc=0x15, dac=0x3F -> serialEn high for 18 cycles, done in cycle 19; chain fields read 0x2A/0x15/0x3F.
REQ-031 Second load clock=0x01, adc=0x02, dac=0x03 with READBACK_EN -> rb* = 0x2A/0x15/0x3F at done; without READBACK_EN -> rb*=0.
REQ-032 startValid held high continuously -> back-to-back loads every 20 cycles; the second start is not accepted while busy.
REQ-033 reset asserted at shift cycle 9 -> next cycle IDLE, serialEn=0, no done pulse, chain=0; a subsequent load of 0x3F/0x3F/0x3F completes correctly.
REQ-034 Input fields changed every cycle during SHIFT -> chain holds the values sampled at acceptance only.
